// File: rtl/apb_master.sv
// apb_master: turns a valid/ready request into one APB transfer and returns
// a single-cycle response pulse. Optional ACCESS wait timeout.
//
// Parameters
//   ADDR_WIDTH : bus address width
//   DATA_WIDTH : bus data width
//   TIMEOUT    : max ACCESS wait cycles before abort (0 = never abort)
// Ports
//   pclk, rst                  : clock, synchronous active-high reset
//   req_valid/ready            : request handshake
//   req_addr/wdata/write/stb   : request payload
//   rsp_valid/rdata/err        : one-cycle response pulse, data/err held after
//   paddr/pdata/psel/penable/pwrite/pstb : APB initiator outputs
//   prdata/pready/perr         : APB completer inputs
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [3:0]            req_stb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  localparam int unsigned WaitW = 16;
  localparam bit TimeoutEn = (TIMEOUT != 0);
  // Counter value at which the next unready ACCESS edge is the TIMEOUT-th one.
  localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q;
  logic [WaitW-1:0]      wait_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [3:0]            pstb_q;

  // Transfer FSM with all outputs registered.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstb_q      <= 4'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            paddr_q     <= req_addr;
            pdata_q     <= req_wdata;
            pwrite_q    <= req_write;
            // Reads never carry byte strobes.
            pstb_q      <= req_write ? req_stb : 4'h0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            wait_q      <= '0;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end else begin
            // Covers the first idle cycle after reset release.
            req_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            // Completion wins over a coincident timeout.
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            rsp_err_q   <= perr;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else if (TimeoutEn && (wait_q == TimeoutLast)) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else if (wait_q != '1) begin
            // Saturate so a disabled timeout never wraps.
            wait_q <= wait_q + WaitW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign pdata     = pdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pstb      = pstb_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed test of apb_master (TIMEOUT = 4). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_apb_master;

  logic        pclk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [3:0]  req_stb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic [31:0] prdata;
  logic        pready;
  logic        perr;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_write(req_write),
    .req_stb  (req_stb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .pdata    (pdata),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pstb     (pstb),
    .prdata   (prdata),
    .pready   (pready),
    .perr     (perr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  // One transfer: nwait unready ACCESS cycles, then pready=1 with rdata/err.
  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] stb, input int nwait,
                         input logic [31:0] rdata, input logic err);
    logic [3:0]  exp_stb;
    logic [31:0] exp_rdata;
    exp_stb   = wr ? stb : 4'h0;
    exp_rdata = wr ? 32'h0 : rdata;
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_stb = stb;
    step();
    // SETUP: scramble the request and poke the completer inputs; all must be ignored.
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_stb = ~stb;
    pready = 1'b1; perr = 1'b1; prdata = 32'hBAD0BAD0;
    check_eq({tag, "_setup_sel"}, 64'({psel, penable}), 64'b10);
    check_eq({tag, "_setup_addr"}, 64'(paddr), 64'(addr));
    check_eq({tag, "_setup_wr"}, 64'(pwrite), 64'(wr));
    check_eq({tag, "_setup_stb"}, 64'(pstb), 64'(exp_stb));
    check_eq({tag, "_setup_rdy"}, 64'(req_ready), 64'd0);
    if (wr) check_eq({tag, "_setup_data"}, 64'(pdata), 64'(wdata));
    step();
    pready = 1'b0; perr = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      check_eq({tag, "_wait_sel"}, 64'({psel, penable}), 64'b11);
      check_eq({tag, "_wait_addr"}, 64'(paddr), 64'(addr));
      step();
    end
    check_eq({tag, "_acc_sel"}, 64'({psel, penable}), 64'b11);
    check_eq({tag, "_acc_addr"}, 64'(paddr), 64'(addr));
    check_eq({tag, "_acc_stb"}, 64'(pstb), 64'(exp_stb));
    check_eq({tag, "_acc_rspv"}, 64'(rsp_valid), 64'd0);
    pready = 1'b1; perr = err; prdata = rdata;
    step();
    pready = 1'b0; perr = 1'b0; prdata = 32'h0BAD0BAD;
    check_eq({tag, "_rsp_sel"}, 64'({psel, penable}), 64'b00);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check_eq({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'(err));
    check_eq({tag, "_rsp_ready"}, 64'(req_ready), 64'd1);
    step();
    check_eq({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_post_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check_eq({tag, "_post_err"}, 64'(rsp_err), 64'(err));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    req_stb = 4'h0; prdata = '0; pready = 1'b0; perr = 1'b0;
    step(); step();
    check_eq("reset_outs", 64'({req_ready, rsp_valid, rsp_err, psel, penable, pwrite, pstb}), 64'd0);
    check_eq("reset_paddr", 64'(paddr), 64'd0);
    check_eq("reset_pdata", 64'(pdata), 64'd0);
    check_eq("reset_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    step();
    check_eq("reset_release_ready", 64'(req_ready), 64'd1);

    // Write, pready one cycle after penable: psel/penable 10,11,11,00.
    do_xfer("wr1", 1'b1, 32'h11004000, 32'hDEADBEEF, 4'hF, 1, 32'h77777777, 1'b0);
    // Zero-wait read; strobes dropped.
    do_xfer("rd1", 1'b0, 32'h1100BFF8, 32'h0, 4'hF, 0, 32'h00001234, 1'b0);
    // pready on the edge that would time out: normal completion.
    do_xfer("tie", 1'b0, 32'h00000080, 32'h0, 4'h3, 3, 32'hCAFEF00D, 1'b0);
    // Write with slave error and partial strobes.
    do_xfer("werr", 1'b1, 32'h00000100, 32'h01234567, 4'h5, 2, 32'h0, 1'b1);

    // Timeout: pready held low, exactly 4 ACCESS cycles then error response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00000040; req_stb = 4'hF;
    prdata = 32'hFFFF0000;
    step();
    req_valid = 1'b0;
    check_eq("to_setup", 64'({psel, penable}), 64'b10);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("to_access", 64'({psel, penable, rsp_valid}), 64'b110);
      step();
    end
    check_eq("to_sel", 64'({psel, penable}), 64'b00);
    check_eq("to_valid", 64'(rsp_valid), 64'd1);
    check_eq("to_err", 64'(rsp_err), 64'd1);
    check_eq("to_rdata", 64'(rsp_rdata), 64'd0);
    step();
    check_eq("to_post_valid", 64'(rsp_valid), 64'd0);

    // Reset in the second ACCESS cycle drops the transfer silently.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h00002000; req_wdata = 32'h1; req_stb = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    check_eq("rst_acc1", 64'({psel, penable}), 64'b11);
    step();
    check_eq("rst_acc2", 64'({psel, penable}), 64'b11);
    rst = 1'b1;
    step();
    rst = 1'b0; pready = 1'b1; perr = 1'b1;
    check_eq("rst_outs", 64'({req_ready, rsp_valid, rsp_err, psel, penable, pwrite, pstb}), 64'd0);
    check_eq("rst_paddr", 64'(paddr), 64'd0);
    check_eq("rst_pdata", 64'(pdata), 64'd0);
    step();
    pready = 1'b0; perr = 1'b0;
    check_eq("rst_rel_ready", 64'(req_ready), 64'd1);
    check_eq("rst_rel_valid", 64'({rsp_valid, psel}), 64'd0);
    step();
    check_eq("rst_rel_valid2", 64'({rsp_valid, psel}), 64'd0);

    // Back-to-back: second request accepted in the first's response cycle.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h00003000; req_wdata = 32'h11111111; req_stb = 4'hF;
    step();
    req_write = 1'b0; req_addr = 32'h00003004; req_wdata = 32'h22222222;
    check_eq("b2b_a_setup", 64'({psel, penable}), 64'b10);
    check_eq("b2b_a_addr", 64'(paddr), 64'h00003000);
    step();
    check_eq("b2b_a_access", 64'({psel, penable}), 64'b11);
    pready = 1'b1; perr = 1'b1;
    step();
    pready = 1'b0; perr = 1'b0;
    check_eq("b2b_a_rsp", 64'({rsp_valid, rsp_err, req_ready, psel}), 64'b1110);
    step();
    req_valid = 1'b0;
    check_eq("b2b_b_setup", 64'({psel, penable, pwrite}), 64'b100);
    check_eq("b2b_b_addr", 64'(paddr), 64'h00003004);
    check_eq("b2b_b_held", 64'({rsp_valid, rsp_err}), 64'b01);
    step();
    check_eq("b2b_b_access", 64'({psel, penable}), 64'b11);
    pready = 1'b1; prdata = 32'h5555AAAA;
    step();
    pready = 1'b0;
    check_eq("b2b_b_rsp", 64'({rsp_valid, rsp_err}), 64'b10);
    check_eq("b2b_b_rdata", 64'(rsp_rdata), 64'h5555AAAA);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum ACCESS wait cycles (1..65535); 0 disables the timeout.
REQ-004 The block SHALL have port pclk  input  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid  input  1  request present.
REQ-007 The block SHALL have port req_ready  output  1  request accepted when req_valid && req_ready at an edge.
REQ-008 The block SHALL have port req_addr  input  ADDR_WIDTH  transfer address.
REQ-009 The block SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 The block SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-011 The block SHALL have port req_stb  input  4  write byte strobes.
REQ-012 The block SHALL have port rsp_valid  output  1  one-cycle response pulse; requester always accepts it.
REQ-013 The block SHALL have port rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid.
REQ-014 The block SHALL have port rsp_err  output  1  error flag (perr or timeout), valid with rsp_valid.
REQ-015 The block SHALL have ports paddr (output, ADDR_WIDTH), pdata (output, DATA_WIDTH), psel, penable and pwrite (output, 1 each), pstb (output, 4), prdata (input, DATA_WIDTH), pready and perr (input, 1 each): the APB initiator side.

Function
REQ-016 All outputs SHALL be registered; state machine states SHALL be IDLE, SETUP and ACCESS.
REQ-017 req_ready SHALL be 1 exactly while in IDLE and not in reset.
REQ-018 On acceptance in IDLE, the block SHALL capture req_addr/req_wdata/req_write/req_stb into paddr/pdata/pwrite/pstb, set psel=1 and penable=0, and go to SETUP.
REQ-019 For reads, pstb SHALL be driven 4'b0000 regardless of req_stb; pdata SHALL hold the last captured value.
REQ-020 SETUP SHALL last exactly one cycle, then penable=1 and the state SHALL go to ACCESS.
REQ-021 paddr, pdata, pwrite and pstb SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-022 In ACCESS, an edge with pready=1 SHALL complete the transfer: psel=0, penable=0, rsp_valid=1, rsp_rdata=prdata for reads or 0 for writes, rsp_err=perr, state=IDLE.
REQ-023 In ACCESS with pready=0, a 16-bit wait counter SHALL increment; it SHALL clear on entering SETUP.
REQ-024 If TIMEOUT!=0 and the wait counter reaches TIMEOUT with pready still 0, the block SHALL abort at that edge: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, state=IDLE.
REQ-025 If pready=1 arrives on the same edge as the timeout condition, pready SHALL win (normal completion).
REQ-026 rsp_valid SHALL be high for exactly one cycle per accepted request; rsp_rdata/rsp_err SHALL hold until the next response.
REQ-027 Because state is IDLE in the rsp_valid cycle, a new request SHALL be acceptable in that same cycle; throughput with a zero-wait slave SHALL be one transfer per 3 cycles.
REQ-028 Latency SHALL be: acceptance edge k, SETUP in cycle k+1, ACCESS from k+2; rsp_valid asserts after the first edge in ACCESS at which pready=1.
REQ-029 pready, prdata and perr SHALL be ignored outside ACCESS.

Reset
REQ-030 When rst=1 at an edge, the block SHALL force state=IDLE, psel=0, penable=0, pwrite=0, pstb=0, paddr=0, pdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, and req_ready=0 while rst=1.
REQ-031 Reset during SETUP or ACCESS SHALL drop the transfer without producing rsp_valid.

Verification
REQ-032 Write 0x11004000 with data 0xDEADBEEF and stb 0xF to a slave whose pready rises one cycle after penable -> psel/penable sequence 10,11,11,00; rsp_valid at the 4th cycle after acceptance; rsp_err=0.
REQ-033 Read 0x1100BFF8 with the slave returning 0x00001234 and req_stb 0xF -> pstb=0, rsp_rdata=0x00001234, rsp_err=0.
REQ-034 pready held 0 with TIMEOUT=4 -> exactly 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, psel=0.
REQ-035 rst=1 asserted in the second ACCESS cycle -> next cycle all outputs 0, no rsp_valid ever, req_ready=1 after rst drops.
REQ-036 Two back-to-back requests with req_valid held high and perr=1 on the first -> second accepted in the rsp_valid cycle of the first; responses carry rsp_err 1 then 0.
